// File: rtl/clap_pattern_detector.sv
// Clap pattern detector: counts a train of acoustic claps on the mic sample
// stream, each gap bounded by a [MIN_GAP, MAX_GAP] window, and toggles the
// home light state with a one-cycle pulse once CLAP_COUNT claps are seen.
module clap_pattern_detector #(
    parameter int unsigned SAMPLE_W   = 10,
    parameter int unsigned CLAP_COUNT = 2,
    parameter int unsigned THRESH     = 770,
    parameter int unsigned HYST       = 64,
    parameter int unsigned MIN_GAP    = 12000000,
    parameter int unsigned MAX_GAP    = 96000000,
    parameter int unsigned LOCKOUT    = 96000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clk_48,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] mic_sample,
    input  logic [SAMPLE_W-1:0] thresh_in,
    input  logic                use_thresh_in,
    output logic                home_state,
    output logic                toggle_pulse,
    output logic [3:0]          clap_cnt,
    output logic [3:0]          debug
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StGapMin   = 3'd1,
        StWaitNext = 3'd2,
        StToggle   = 3'd3,
        StLockout  = 3'd4
    } state_e;

    localparam logic [SAMPLE_W-1:0] ThreshDef  = SAMPLE_W'(THRESH);
    localparam logic [CNT_W-1:0]    MinGapCnt  = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0]    MaxGapCnt  = CNT_W'(MAX_GAP);
    localparam logic [CNT_W-1:0]    LockoutCnt = CNT_W'(LOCKOUT);
    localparam logic [3:0]          ClapTarget = 4'(CLAP_COUNT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [3:0]          clap_cnt_q, clap_cnt_d;
    logic                armed_q, armed_d;
    logic                home_state_q, home_state_d;
    logic                toggle_pulse_q, toggle_pulse_d;

    logic [SAMPLE_W-1:0] thresh;
    logic [SAMPLE_W-1:0] release_lvl;
    logic                clap_event;
    logic [3:0]          clap_cnt_inc;

    // Active threshold and the hysteresis release level (saturates at zero).
    always_comb begin
        thresh = use_thresh_in ? thresh_in : ThreshDef;
        if (32'(thresh) > HYST) begin
            release_lvl = SAMPLE_W'(32'(thresh) - HYST);
        end else begin
            release_lvl = '0;
        end
    end

    // Edge detector: one event per excursion above thresh, re-armed below release.
    always_comb begin
        clap_event = armed_q && (mic_sample > thresh);
        armed_d    = armed_q;
        if (clap_event) begin
            armed_d = 1'b0;
        end else if (!armed_q && (mic_sample < release_lvl)) begin
            armed_d = 1'b1;
        end
    end

    assign clap_cnt_inc = clap_cnt_q + 4'd1;

    // Pattern FSM next-state, timer and clap counter.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        clap_cnt_d = clap_cnt_q;
        case (state_q)
            StIdle: begin
                if (clap_event) begin
                    clap_cnt_d = 4'd1;
                    if (CLAP_COUNT == 1) begin
                        state_d = StToggle;
                    end else begin
                        state_d = StGapMin;
                        timer_d = MinGapCnt;
                    end
                end
            end
            StGapMin: begin
                // Claps arriving here are consumed by the edge detector but not counted.
                if (timer_q == '0) begin
                    state_d = StWaitNext;
                    timer_d = MaxGapCnt;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StWaitNext: begin
                // Timeout takes priority over a clap landing on the same cycle.
                if (timer_q == '0) begin
                    state_d    = StIdle;
                    clap_cnt_d = 4'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (clap_event) begin
                        clap_cnt_d = clap_cnt_inc;
                        if (clap_cnt_inc == ClapTarget) begin
                            state_d = StToggle;
                        end else begin
                            state_d = StGapMin;
                            timer_d = MinGapCnt;
                        end
                    end
                end
            end
            StToggle: begin
                clap_cnt_d = 4'd0;
                timer_d    = LockoutCnt;
                state_d    = StLockout;
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Light state flips and the pulse fires on the edge leaving StToggle.
    always_comb begin
        toggle_pulse_d = (state_q == StToggle);
        home_state_d   = home_state_q ^ toggle_pulse_d;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            clap_cnt_q     <= 4'd0;
            armed_q        <= 1'b1;
            home_state_q   <= 1'b0;
            toggle_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            clap_cnt_q     <= clap_cnt_d;
            armed_q        <= armed_d;
            home_state_q   <= home_state_d;
            toggle_pulse_q <= toggle_pulse_d;
        end
    end

    assign home_state   = home_state_q;
    assign toggle_pulse = toggle_pulse_q;
    assign clap_cnt     = clap_cnt_q;
    assign debug        = {armed_q, state_q};

endmodule

// File: doc/clap_pattern_detector.md
Name: clap_pattern_detector

Overview:
Parametrised successor to the two-clap light toggle. Detects a train of CLAP_COUNT acoustic claps on the 10-bit mic sample stream. Each clap gap must fall inside a [MIN_GAP, MAX_GAP] window. On a valid train it toggles home_state and emits a one-cycle pulse. Adds hysteresis-based edge detection, so one loud clap spanning many cycles counts once, plus a runtime threshold override. Sits between the mic ADC sampler and the light/relay driver.

Parameters:
SAMPLE_W, 10, mic_sample width
CLAP_COUNT, 2, claps per valid pattern (1..15)
THRESH, 770, default trigger level
HYST, 64, re-arm margin; release level = thresh - HYST, saturating at 0
MIN_GAP, 12000000, cycles after a clap during which claps are ignored
MAX_GAP, 96000000, cycles allowed to receive the next clap
LOCKOUT, 96000000, dead time after a toggle
CNT_W, 32, timer width; must hold max(MIN_GAP, MAX_GAP, LOCKOUT)

Ports:
clk_48  in  1  48 MHz clock
rst  in  1  reset, asynchronous, active-high
mic_sample  in  SAMPLE_W  unsigned mic level
thresh_in  in  SAMPLE_W  runtime threshold
use_thresh_in  in  1  1: thresh = thresh_in; 0: thresh = THRESH
home_state  out  1  light state, 1 = on
toggle_pulse  out  1  high one cycle when home_state flips
clap_cnt  out  4  claps accepted in current pattern
debug  out  4  {armed, state[2:0]}

Behaviour:
- Reset (async, rst high): state=IDLE, timer=0, clap_cnt=0, armed=1, home_state=0, toggle_pulse=0. Reset mid-pattern aborts the pattern and does not preserve home_state.
- Edge detector, independent of state:
  - event = armed && mic_sample > thresh (strict greater-than).
  - On event, armed<=0.
  - When !armed && mic_sample < release, armed<=1.
  - Between release and thresh, armed holds.
  - A sample held above thresh produces exactly one event.
- All compares are unsigned. Thresh is evaluated combinationally each cycle.
- State encoding: IDLE=0, GAP_MIN=1, WAIT_NEXT=2, TOGGLE=3, LOCKOUT=4. Codes 5-7 go to IDLE.
- IDLE:
  - On event, clap_cnt<=1.
  - If CLAP_COUNT==1, go to TOGGLE.
  - Otherwise go to GAP_MIN with timer<=MIN_GAP.
- GAP_MIN:
  - If timer==0, go to WAIT_NEXT with timer<=MAX_GAP.
  - Otherwise timer decrements.
  - Events are consumed (armed clears) but ignored.
  - Dwell is MIN_GAP+1 cycles.
- WAIT_NEXT:
  - If timer==0, go to IDLE with clap_cnt<=0. Timeout wins over a simultaneous event.
  - Otherwise timer decrements. On event, clap_cnt<=clap_cnt+1.
  - If the new count == CLAP_COUNT, go to TOGGLE; otherwise go to GAP_MIN with timer<=MIN_GAP.
- TOGGLE (one cycle):
  - home_state<=~home_state, toggle_pulse<=1.
  - clap_cnt<=0, timer<=LOCKOUT, go to LOCKOUT.
- LOCKOUT:
  - If timer==0, go to IDLE; otherwise timer decrements.
  - Events are ignored. Dwell is LOCKOUT+1 cycles.
- toggle_pulse is registered. It is high exactly in the cycle after the TOGGLE state cycle, the same cycle home_state shows its new value, and 0 at all other times.
- Latency: the qualifying sample seen at edge k puts state=TOGGLE after edge k. home_state and toggle_pulse update after edge k+1.
- The timer never underflows, because decrement happens only when timer!=0.
- If use_thresh_in toggles mid-pattern, the new threshold applies from the next compare. Pattern progress is kept.

Test Plan:
- Config for all tests: CLAP_COUNT=3, MIN_GAP=4, MAX_GAP=8, LOCKOUT=6, THRESH=770, HYST=64.
- Three pulses (sample 900 for 2 cycles, then 0), each spaced so it lands in WAIT_NEXT -> clap_cnt steps 1,2,3. home_state goes 0->1 two edges after the third qualifying sample, with toggle_pulse high exactly 1 cycle. Repeat after LOCKOUT expires -> home_state goes 1->0.
- Sample held at 900 for 30 cycles -> one event only, clap_cnt=1, no toggle. Sample at 750 (above release 706, below thresh) after a clap -> no re-arm; a later 900 is not counted until the sample drops below 706.
- Second clap during GAP_MIN (2 cycles after the first) -> ignored, clap_cnt stays 1. No third clap within 9 WAIT_NEXT cycles -> IDLE, clap_cnt=0, home_state unchanged.
- Event on the exact cycle WAIT_NEXT timer==0 -> goes to IDLE, clap_cnt=0, no toggle.
- Claps during LOCKOUT -> no clap_cnt change. use_thresh_in=1 with thresh_in=500: sample 600 counts as a clap. With use_thresh_in=0, sample 600 is ignored.
- Assert rst asynchronously mid-WAIT_NEXT with home_state=1 -> immediately state=IDLE, home_state=0, clap_cnt=0, debug=4'b1000.
